crc_job_seq: RTL and testbench
==============================

Name: crc_job_seq

Overview:
- Bus-master sequencer that runs complete CRC jobs on the memory-mapped CRC engine (CTRL / GPOLY / DATA registers) over its Sel/RW/addr/data register bus.
- A client latches a job configuration with a start pulse, then streams data words through a valid/ready port.
- The block programs the engine, writes the seed, forwards every word, reads back the final CRC and returns it with a done pulse.
- It sits between the CRC engine and a DMA or CPU-side producer, so software never sequences the engine registers itself.

Parameters:
- DATA_ADDR, 32'h4003_2000, engine CRC_DATA register address
- GPOLY_ADDR, 32'h4003_2004, engine CRC_GPOLY register address
- CTRL_ADDR, 32'h4003_2008, engine CRC_CTRL register address
- LEN_W, 16, width of the job word count

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- start  in  1  job request; sampled only when busy=0
- abort  in  1  cancel current job
- cfg_tot  in  2  write transpose type
- cfg_totr  in  2  read transpose type
- cfg_fxor  in  1  complement result on read
- cfg_tcrc  in  1  1=32-bit CRC, 0=16-bit
- cfg_poly  in  32  polynomial
- cfg_seed  in  32  seed
- cfg_len  in  LEN_W  number of data words
- s_valid  in  1  data word valid
- s_data  in  32  data word
- s_ready  out  1  data word accepted when s_valid&s_ready
- sel  out  1  bus select to engine
- rw  out  1  1=write, 0=read
- addr  out  32  bus address
- data_wr  out  32  bus write data
- data_rd  in  32  bus read data (combinational from engine)
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: job aborted or cfg_len=0
- result  out  32  final CRC; held until next done

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE. sel=0, rw=0, addr=0, data_wr=0, s_ready=0, busy=0, done=0, err=0, result=0, word counter=0.
- Reset mid-job: abandons the job with no done pulse.
- All bus outputs are registered.
- When sel=0, rw/addr/data_wr are don't-care, but the bench expects rw=0.
- CTRL word = {tot, totr, 1'b0, fxor, WAS, tcrc, 24'h0}.
- States: IDLE, W_CTRL_S, W_POLY, W_SEED, W_CTRL_D, DATA, W_LAST, READ, DONE.
- IDLE: on start=1, latch all cfg_* and go to W_CTRL_S.
  - If cfg_len=0: go to DONE with err=1 and no bus traffic.
- W_CTRL_S: one write to CTRL_ADDR with WAS=1.
- W_POLY: one write to GPOLY_ADDR with cfg_poly.
- W_SEED: one write to DATA_ADDR with cfg_seed.
- W_CTRL_D: one write to CTRL_ADDR with WAS=0.
- Each setup state lasts exactly one cycle. busy=1 from the first cycle after start through READ.
- DATA:
  - s_ready=1 in DATA only.
  - A handshake in cycle k produces a write to DATA_ADDR with that word in cycle k+1.
  - Back-to-back words are allowed at 1 word/cycle. Cycles with no handshake put sel=0 in the following cycle.
  - The counter loads cfg_len and decrements per handshake. When the last word is accepted, go to W_LAST (the last word's write cycle) with s_ready=0.
- READ: the cycle after W_LAST.
  - Drives sel=1, rw=0, addr=DATA_ADDR.
  - result is captured from data_rd at the end of READ.
- DONE: done=1, busy=0 for one cycle, then IDLE.
  - start is ignored in DONE.
  - start asserted while busy=1 is ignored.
- Latency: start to first bus write is 1 cycle. Last word accepted to done is 3 cycles.
- abort:
  - Any non-IDLE, non-DONE state goes to DONE with err=1 next cycle. Any pending word write is dropped, sel=0, and result is unchanged.
  - abort in IDLE is ignored. abort together with start in IDLE means start is ignored.
- The counter never underflows. Words offered after the count reaches zero are not accepted.

Test Plan:
- tcrc=1, fxor=0, tot=totr=0, poly=0x04C11DB7, seed=0, len=1, word 0x00000000 -> bus writes CTRL 0x03000000, GPOLY 0x04C11DB7, DATA 0x00000000, CTRL 0x01000000, DATA 0x00000000; read; result=0x00000000, err=0, done 3 cycles after handshake.
- Same but word 0x00000001 and fxor=1 -> CTRL writes 0x07000000 then 0x05000000; result=0xFFFFFFFE.
- len=4, s_valid held high -> four consecutive DATA writes with sel=1 every cycle; s_ready drops after 4th handshake; exactly one READ.
- len=3 with s_valid gaps of 2 cycles -> sel=0 in gap cycles; result identical to the gapless run of the same words.
- abort during DATA after 1 of 3 words -> next cycle done=1, err=1, result unchanged, no READ issued; start during busy ignored.
- cfg_len=0 -> no sel activity, done=1 err=1 one cycle after start; rst mid-job -> all outputs at reset values next cycle, no done.

Source files
------------

// File: rtl/crc_job_seq.sv
// CRC job sequencer: programs the memory-mapped CRC engine, streams the job's
// data words onto the engine bus and returns the final CRC with a done pulse.
module crc_job_seq #(
  parameter logic [31:0] DATA_ADDR  = 32'h4003_2000,
  parameter logic [31:0] GPOLY_ADDR = 32'h4003_2004,
  parameter logic [31:0] CTRL_ADDR  = 32'h4003_2008,
  parameter int          LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_tot,
  input  logic [1:0]       cfg_totr,
  input  logic             cfg_fxor,
  input  logic             cfg_tcrc,
  input  logic [31:0]      cfg_poly,
  input  logic [31:0]      cfg_seed,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             sel,
  output logic             rw,
  output logic [31:0]      addr,
  output logic [31:0]      data_wr,
  input  logic [31:0]      data_rd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      result
);

  typedef enum logic [3:0] {
    IDLE, W_CTRL_S, W_POLY, W_SEED, W_CTRL_D, DATA, W_LAST, READ, DONE
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       tot_r, totr_r;
  logic             fxor_r, tcrc_r;
  logic [31:0]      poly_r, seed_r;
  logic [LEN_W-1:0] cnt_r, cnt_s;
  logic             load_s, hs_s, sel_s, rw_s, err_s;
  logic [31:0]      addr_s, data_s;

  function automatic logic [31:0] ctrl_word(input logic [1:0] tot, input logic [1:0] totr,
                                            input logic fxor, input logic was, input logic tcrc);
    return {tot, totr, 1'b0, fxor, was, tcrc, 24'h00_0000};
  endfunction

  assign hs_s = s_valid & s_ready & (cnt_r != {LEN_W{1'b0}});

  // Next state plus the bus cycle that belongs to that next state.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    sel_s   = 1'b0;
    rw_s    = 1'b0;
    addr_s  = 32'h0000_0000;
    data_s  = 32'h0000_0000;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          load_s = 1'b1;
          if (cfg_len == {LEN_W{1'b0}}) begin
            state_s = DONE;
            err_s   = 1'b1;
          end else begin
            state_s = W_CTRL_S;
            cnt_s   = cfg_len;
            sel_s   = 1'b1;
            rw_s    = 1'b1;
            addr_s  = CTRL_ADDR;
            data_s  = ctrl_word(cfg_tot, cfg_totr, cfg_fxor, 1'b1, cfg_tcrc);
          end
        end else begin
          state_s = IDLE;
        end
      end
      W_CTRL_S: begin
        state_s = W_POLY;
        sel_s   = 1'b1;
        rw_s    = 1'b1;
        addr_s  = GPOLY_ADDR;
        data_s  = poly_r;
      end
      W_POLY: begin
        state_s = W_SEED;
        sel_s   = 1'b1;
        rw_s    = 1'b1;
        addr_s  = DATA_ADDR;
        data_s  = seed_r;
      end
      W_SEED: begin
        state_s = W_CTRL_D;
        sel_s   = 1'b1;
        rw_s    = 1'b1;
        addr_s  = CTRL_ADDR;
        data_s  = ctrl_word(tot_r, totr_r, fxor_r, 1'b0, tcrc_r);
      end
      W_CTRL_D: state_s = DATA;
      DATA: begin
        if (hs_s) begin
          cnt_s  = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
          sel_s  = 1'b1;
          rw_s   = 1'b1;
          addr_s = DATA_ADDR;
          data_s = s_data;
          if (cnt_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_s = W_LAST;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      W_LAST: begin
        state_s = READ;
        sel_s   = 1'b1;
        addr_s  = DATA_ADDR;
      end
      READ:    state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    // Abort wins over everything in flight, including a word handshaken this cycle.
    if (abort && state_r != IDLE && state_r != DONE) begin
      state_s = DONE;
      sel_s   = 1'b0;
      rw_s    = 1'b0;
      addr_s  = 32'h0000_0000;
      data_s  = 32'h0000_0000;
      err_s   = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // State, latched job configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {LEN_W{1'b0}};
      tot_r   <= 2'b00;
      totr_r  <= 2'b00;
      fxor_r  <= 1'b0;
      tcrc_r  <= 1'b0;
      poly_r  <= 32'h0000_0000;
      seed_r  <= 32'h0000_0000;
      sel     <= 1'b0;
      rw      <= 1'b0;
      addr    <= 32'h0000_0000;
      data_wr <= 32'h0000_0000;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (load_s) begin
        tot_r  <= cfg_tot;
        totr_r <= cfg_totr;
        fxor_r <= cfg_fxor;
        tcrc_r <= cfg_tcrc;
        poly_r <= cfg_poly;
        seed_r <= cfg_seed;
      end
      sel     <= sel_s;
      rw      <= rw_s;
      addr    <= addr_s;
      data_wr <= data_s;
      s_ready <= (state_s == DATA);
      busy    <= (state_s != IDLE) && (state_s != DONE);
      done    <= (state_s == DONE);
      err     <= err_s;
      if (state_r == READ && !abort) begin
        result <= data_rd;
      end
    end
  end

endmodule

// File: tb/tb_crc_job_seq.sv
// Self-checking bench for crc_job_seq: a behavioural CRC-engine stand-in on the
// register bus, a table of directed jobs, hand-written corner sequences and random jobs.
module tb_crc_job_seq;
  localparam logic [31:0] DATA_ADDR  = 32'h4003_2000;
  localparam logic [31:0] GPOLY_ADDR = 32'h4003_2004;
  localparam logic [31:0] CTRL_ADDR  = 32'h4003_2008;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] cfg_tot = 2'b00, cfg_totr = 2'b00;
  logic cfg_fxor = 1'b0, cfg_tcrc = 1'b0;
  logic [31:0] cfg_poly = 32'h0, cfg_seed = 32'h0;
  logic [15:0] cfg_len = 16'h0;
  logic s_valid = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic s_ready, sel, rw, busy, done, err;
  logic [31:0] addr, data_wr, data_rd, result;

  crc_job_seq #(.DATA_ADDR(DATA_ADDR), .GPOLY_ADDR(GPOLY_ADDR), .CTRL_ADDR(CTRL_ADDR), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_tot(cfg_tot), .cfg_totr(cfg_totr),
    .cfg_fxor(cfg_fxor), .cfg_tcrc(cfg_tcrc), .cfg_poly(cfg_poly), .cfg_seed(cfg_seed),
    .cfg_len(cfg_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .sel(sel), .rw(rw),
    .addr(addr), .data_wr(data_wr), .data_rd(data_rd), .busy(busy), .done(done), .err(err),
    .result(result));

  always #5 clk = ~clk;

  logic [31:0] cyc = 32'h0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Engine stand-in: WAS=1 makes a DATA write load the accumulator, otherwise words are folded in by XOR.
  logic [31:0] eng_ctrl = 32'h0;
  logic [31:0] eng_acc = 32'h0;
  always @(posedge clk) begin
    if (sel && rw) begin
      if (addr == CTRL_ADDR) eng_ctrl <= data_wr;
      else if (addr == DATA_ADDR) eng_acc <= eng_ctrl[25] ? data_wr : (eng_acc ^ data_wr);
    end
  end
  assign data_rd = (sel && !rw && addr == DATA_ADDR) ? (eng_ctrl[26] ? ~eng_acc : eng_acc) : 32'h0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;
  ent_t log_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (sel) log_q.push_back('{cyc, rw, addr, (rw ? data_wr : 32'h0)});
      else chk("idle_rw", {31'h0, rw}, 32'h0);
    end
  end

  function automatic logic [31:0] ctrl_of(input logic [1:0] tot, input logic [1:0] totr,
                                          input logic fxor, input logic was, input logic tcrc);
    return {tot, totr, 1'b0, fxor, was, tcrc, 24'h0};
  endfunction

  logic [31:0] wbuf[8];
  int gbuf[8];

  task automatic cycle1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_job(input logic [1:0] tot, input logic [1:0] totr, input logic fxor,
                         input logic tcrc, input logic [31:0] poly, input logic [31:0] seed,
                         input int len, input int abort_after, input logic [31:0] exp_res,
                         input logic [31:0] exp_ctrl, input string nm);
    ent_t exp_q[$];
    logic [31:0] prev_res, s_cyc, hs_cyc;
    int nacc, waitc;
    bit tmo;
    prev_res = result;
    log_q.delete();
    cfg_tot = tot; cfg_totr = totr; cfg_fxor = fxor; cfg_tcrc = tcrc;
    cfg_poly = poly; cfg_seed = seed; cfg_len = len[15:0];
    start = 1'b1;
    s_cyc = cyc;
    cycle1();
    start = 1'b0;
    if (len == 0) begin
      chk({nm, "_len0_done"}, {31'h0, done}, 32'h1);
      chk({nm, "_len0_err"}, {31'h0, err}, 32'h1);
      chk({nm, "_len0_busy"}, {31'h0, busy}, 32'h0);
      chk({nm, "_len0_result"}, result, exp_res);
      cycle1();
      chk({nm, "_len0_pulse"}, {31'h0, done}, 32'h0);
      chk({nm, "_len0_nobus"}, log_q.size(), 32'h0);
      return;
    end
    chk({nm, "_busy"}, {31'h0, busy}, 32'h1);
    exp_q.push_back('{s_cyc + 32'd1, 1'b1, CTRL_ADDR, ctrl_of(tot, totr, fxor, 1'b1, tcrc)});
    exp_q.push_back('{s_cyc + 32'd2, 1'b1, GPOLY_ADDR, poly});
    exp_q.push_back('{s_cyc + 32'd3, 1'b1, DATA_ADDR, seed});
    exp_q.push_back('{s_cyc + 32'd4, 1'b1, CTRL_ADDR, ctrl_of(tot, totr, fxor, 1'b0, tcrc)});
    nacc = 0; tmo = 0; hs_cyc = 32'h0;
    while (nacc < len && nacc != abort_after && !tmo) begin
      repeat (gbuf[nacc]) cycle1();
      s_valid = 1'b1;
      s_data = wbuf[nacc];
      waitc = 0;
      while (!s_ready && waitc < 40) begin cycle1(); waitc++; end
      if (!s_ready) begin
        tmo = 1;
        chk({nm, "_ready_timeout"}, {31'h0, s_ready}, 32'h1);
      end else begin
        hs_cyc = cyc;
        exp_q.push_back('{hs_cyc + 32'd1, 1'b1, DATA_ADDR, wbuf[nacc]});
        nacc++;
        if (nacc == 1) begin
          // start while busy, with a config that would visibly differ if relatched
          start = 1'b1; cfg_len = 16'd0; cfg_poly = ~poly; cfg_fxor = ~fxor;
        end
        cycle1();
        s_valid = 1'b0;
        start = 1'b0;
      end
    end
    s_valid = 1'b0;
    if (tmo) return;
    if (abort_after >= 0 && nacc == abort_after) begin
      waitc = 0;
      while (!s_ready && waitc < 40) begin cycle1(); waitc++; end
      abort = 1'b1;
      cycle1();
      abort = 1'b0;
      chk({nm, "_abort_done"}, {31'h0, done}, 32'h1);
      chk({nm, "_abort_err"}, {31'h0, err}, 32'h1);
      chk({nm, "_abort_result"}, result, prev_res);
      chk({nm, "_abort_busy"}, {31'h0, busy}, 32'h0);
      chk({nm, "_abort_sel"}, {31'h0, sel}, 32'h0);
    end else begin
      exp_q.push_back('{hs_cyc + 32'd2, 1'b0, DATA_ADDR, 32'h0});
      waitc = 0;
      while (!done && waitc < 20) begin cycle1(); waitc++; end
      chk({nm, "_done"}, {31'h0, done}, 32'h1);
      chk({nm, "_latency"}, cyc - hs_cyc, 32'd3);
      chk({nm, "_err"}, {31'h0, err}, 32'h0);
      chk({nm, "_result"}, result, exp_res);
      chk({nm, "_busy_done"}, {31'h0, busy}, 32'h0);
    end
    // start during the done cycle must be ignored
    start = 1'b1; cfg_len = 16'd5;
    cycle1();
    start = 1'b0;
    chk({nm, "_start_in_done"}, {31'h0, busy}, 32'h0);
    chk({nm, "_done_pulse"}, {31'h0, done}, 32'h0);
    chk({nm, "_log_size"}, log_q.size(), exp_q.size());
    if (log_q.size() > 0) chk({nm, "_ctrl_s"}, log_q[0].data, exp_ctrl);
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_bus%0d_cyc", nm, i), log_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s_bus%0d_rw", nm, i), {31'h0, log_q[i].rw}, {31'h0, exp_q[i].rw});
      chk($sformatf("%s_bus%0d_addr", nm, i), log_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_bus%0d_data", nm, i), log_q[i].data, exp_q[i].data);
    end
  endtask

  typedef struct packed {
    logic [1:0] tot, totr;
    logic fxor, tcrc;
    logic [31:0] poly, seed;
    logic [7:0] len;
    logic [3:0][31:0] w;
    logic [7:0] gap;
    logic [31:0] exp_res, exp_ctrl;
  } vec_t;
  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int len, ab;
    bit saw_done;
    // tcrc=1 polynomial 0x04C11DB7 jobs, then a transposed 16-bit job with and without gaps, then len=0
    vt[0] = '{2'd0, 2'd0, 1'b0, 1'b1, 32'h04C11DB7, 32'h0, 8'd1, {32'h0, 32'h0, 32'h0, 32'h0}, 8'd0, 32'h0000_0000, 32'h0300_0000};
    vt[1] = '{2'd0, 2'd0, 1'b1, 1'b1, 32'h04C11DB7, 32'h0, 8'd1, {32'h0, 32'h0, 32'h0, 32'h1}, 8'd0, 32'hFFFF_FFFE, 32'h0700_0000};
    vt[2] = '{2'd0, 2'd0, 1'b0, 1'b1, 32'h04C11DB7, 32'h0, 8'd4, {32'h8, 32'h4, 32'h2, 32'h1}, 8'd0, 32'h0000_000F, 32'h0300_0000};
    vt[3] = '{2'd2, 2'd1, 1'b0, 1'b0, 32'h0000_1021, 32'hFFFF_0000, 8'd3, {32'h0, 32'h44, 32'h22, 32'h11}, 8'd2, 32'hFFFF_0077, 32'h9200_0000};
    vt[4] = '{2'd2, 2'd1, 1'b0, 1'b0, 32'h0000_1021, 32'hFFFF_0000, 8'd3, {32'h0, 32'h44, 32'h22, 32'h11}, 8'd0, 32'hFFFF_0077, 32'h9200_0000};
    vt[5] = '{2'd0, 2'd0, 1'b0, 1'b1, 32'h04C11DB7, 32'h0, 8'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 8'd0, 32'hFFFF_0077, 32'h0};

    repeat (2) cycle1();
    chk("rst_sel", {31'h0, sel}, 32'h0);
    chk("rst_busy_done_err_ready", {28'h0, busy, done, err, s_ready}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_result", result, 32'h0);
    rst = 1'b0;
    cycle1();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        wbuf[i] = vt[v].w[i];
        gbuf[i] = (i == 0) ? 0 : int'(vt[v].gap);
      end
      run_job(vt[v].tot, vt[v].totr, vt[v].fxor, vt[v].tcrc, vt[v].poly, vt[v].seed,
              int'(vt[v].len), -1, vt[v].exp_res, vt[v].exp_ctrl, $sformatf("vec%0d", v));
    end

    // abort in DATA after one of three words
    wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    gbuf[0] = 0; gbuf[1] = 0; gbuf[2] = 0;
    run_job(2'd0, 2'd0, 1'b0, 1'b1, 32'h04C11DB7, 32'h0, 3, 1, 32'h0, 32'h0300_0000, "abort1");

    // abort together with start in IDLE: no job
    log_q.delete();
    cfg_len = 16'd3; start = 1'b1; abort = 1'b1;
    cycle1();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_start_busy", {31'h0, busy}, 32'h0);
    cycle1();
    chk("idle_abort_start_nobus", log_q.size(), 32'h0);

    // reset in the middle of a job
    cfg_len = 16'd3; cfg_seed = 32'h1234_5678; start = 1'b1;
    cycle1();
    start = 1'b0;
    for (int k = 0; k < 40 && !s_ready; k++) cycle1();
    s_valid = 1'b1; s_data = 32'h55;
    cycle1();
    s_valid = 1'b0; rst = 1'b1;
    cycle1();
    chk("midrst_outs", {27'h0, sel, busy, done, err, s_ready}, 32'h0);
    chk("midrst_rw", {31'h0, rw}, 32'h0);
    chk("midrst_addr", addr, 32'h0);
    chk("midrst_data_wr", data_wr, 32'h0);
    chk("midrst_result", result, 32'h0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle1();
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", {31'h0, saw_done}, 32'h0);

    // random jobs against the XOR-engine reference
    for (int j = 0; j < 24; j++) begin
      logic [1:0] t, tr;
      logic fx, tc;
      logic [31:0] p, s;
      t = 2'($urandom_range(0, 3)); tr = 2'($urandom_range(0, 3));
      fx = 1'($urandom_range(0, 1)); tc = 1'($urandom_range(0, 1));
      p = $urandom; s = $urandom;
      len = $urandom_range(1, 6);
      r = s;
      for (int i = 0; i < len; i++) begin
        wbuf[i] = $urandom;
        gbuf[i] = $urandom_range(0, 2);
        r = r ^ wbuf[i];
      end
      if (fx) r = ~r;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run_job(t, tr, fx, tc, p, s, len, ab, r, ctrl_of(t, tr, fx, 1'b1, tc), $sformatf("rnd%0d", j));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
